hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage core: drives enable/flush of PC, IF/ID, ID/EX, EX/MEM, MEM/WB.

---
 rtl/hazard_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline sequencer for the 5-stage core. Drives the load enables of the
//   PC, IF/ID, ID/EX and EX/MEM registers and the flush (NOP/bubble) controls
//   of IF/ID, ID/EX and MEM/WB.
//     - load-use hazard  : one bubble into ID/EX, PC and IF/ID held
//     - taken branch     : the two younger instructions (IF/ID, ID/EX) squashed
//     - dmem wait        : whole pipe frozen, MEM/WB fed a bubble
//     - dmem timeout     : sticky error state, left only through reset
//
//   Optional build macro: HAZARD_CTRL_PERF_EN
//     defined     -> saturating stall / branch-flush performance counters
//     not defined -> counters not built, perf ports tied to zero
//
// Ports
//   clk                     rising-edge clock
//   reset_n                 asynchronous active-low reset
//   id_rs1, id_rs2          source registers of the instruction in ID
//   id_use_rs1, id_use_rs2  instruction in ID actually reads rs1 / rs2
//   ex_rd                   destination register of the instruction in EX
//   ex_mem_re               instruction in EX is a load
//   ex_branch_taken         branch/jump in EX resolved taken
//   mem_access              instruction in MEM accesses data memory
//   dmem_ack                data memory completes this cycle
//   pc_en .. ex_mem_en      stage register load enables
//   if_id_flush, id_ex_flush, mem_wb_flush
//                           load NOP/bubble into that register
//   mem_timeout_err         sticky dmem timeout flag
//   perf_stall_cnt          cycles with pc_en low while running/waiting
//   perf_flush_cnt          taken-branch flush events
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_re,
    input  logic                  ex_branch_taken,
    input  logic                  mem_access,
    input  logic                  dmem_ack,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_en,
    output logic                  ex_mem_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  mem_wb_flush,
    output logic                  mem_timeout_err,
    output logic [CNT_W-1:0]      perf_stall_cnt,
    output logic [CNT_W-1:0]      perf_flush_cnt
);

    // Wide enough to hold MEM_TIMEOUT itself, so the counter never wraps.
    localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_MEM_WAIT,
        ST_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                err_q, err_d;

    logic                mem_stall;
    logic                load_use;
    logic                advance;

    assign mem_stall = mem_access && !dmem_ack;

    // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
    assign load_use = ex_mem_re && (ex_rd != '0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    // -----------------------------------------------------------------------
    // Next-state and control outputs
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        err_d        = err_q;
        advance      = 1'b0;
        // Safe "pipe held, bubbles injected" values used by INIT and ERR.
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b1;
        mem_wb_flush = 1'b1;

        case (state_q)
            ST_INIT: begin
                state_d = ST_RUN;
            end

            ST_RUN: begin
                if (mem_stall) begin
                    id_ex_flush = 1'b0;
                    state_d     = ST_MEM_WAIT;
                    wait_cnt_d  = WAIT_W'(1);
                end else begin
                    advance = 1'b1;
                end
            end

            ST_MEM_WAIT: begin
                // Branch / load-use inputs stay parked in EX/ID while frozen
                // and are serviced on the acknowledge cycle via 'advance'.
                if (dmem_ack) begin
                    advance    = 1'b1;
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else begin
                    id_ex_flush = 1'b0;
                    wait_cnt_d  = wait_cnt_q + WAIT_W'(1);
                    // The entering RUN cycle counted as wait 1, so this
                    // compare ends the freeze after exactly MEM_TIMEOUT cycles.
                    if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end
            end

            ST_ERR: begin
                // Held in the default bubble/freeze values until reset.
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase

        // Normal pipe advance: branch squash beats the load-use bubble, since
        // the dependent instruction in ID is itself squashed by the branch.
        if (advance) begin
            mem_wb_flush = 1'b0;
            id_ex_en     = 1'b1;
            ex_mem_en    = 1'b1;
            if (ex_branch_taken) begin
                pc_en       = 1'b1;
                if_id_en    = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                id_ex_flush = 1'b1;
            end else begin
                pc_en       = 1'b1;
                if_id_en    = 1'b1;
                id_ex_flush = 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_INIT;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: clocked state uses non-blocking assignment so every
            // register samples the pre-edge value of its inputs.
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign mem_timeout_err = err_q;

    // -----------------------------------------------------------------------
    // Performance counters
    // -----------------------------------------------------------------------
`ifdef HAZARD_CTRL_PERF_EN
    logic             counting;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    assign counting = (state_q == ST_RUN) || (state_q == ST_MEM_WAIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (counting && !pc_en && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            // if_id_flush is raised only by a taken-branch squash.
            if (counting && if_id_flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed bench for hazard_ctrl (MEM_TIMEOUT=4, CNT_W=8). A behavioural
//   model describes the pipe in terms of "frozen run length", "still in the
//   first cycle after reset" and "errored"; a compare process checks every
//   output against it on each falling edge. Literal expectations after the
//   directed vectors pin the model to hand-computed values.
//   Control vector order: {pc_en, if_id_en, id_ex_en, ex_mem_en,
//                          if_id_flush, id_ex_flush, mem_wb_flush}
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int MT   = 4;
    localparam int CW   = 8;
    localparam int MAXC = (1 << CW) - 1;
`ifdef HAZARD_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [6:0] C_HOLD   = 7'b0000_011;
    localparam logic [6:0] C_FREEZE = 7'b0000_001;
    localparam logic [6:0] C_BRANCH = 7'b1111_110;
    localparam logic [6:0] C_LDUSE  = 7'b0011_010;
    localparam logic [6:0] C_RUN    = 7'b1111_000;

    typedef struct packed {
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       re;
        logic       br;
        logic       acc;
        logic       ack;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2, ex_mem_re, ex_branch_taken;
    logic          mem_access, dmem_ack;
    logic          pc_en, if_id_en, id_ex_en, ex_mem_en;
    logic          if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout_err;
    logic [CW-1:0] perf_stall_cnt, perf_flush_cnt;
    logic [6:0]    ctl;

    int nvec = 0;
    int nerr = 0;

    hazard_ctrl #(
        .REG_ADDR_W  (5),
        .MEM_TIMEOUT (MT),
        .CNT_W       (CW)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_re       (ex_mem_re),
        .ex_branch_taken (ex_branch_taken),
        .mem_access      (mem_access),
        .dmem_ack        (dmem_ack),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .id_ex_en        (id_ex_en),
        .ex_mem_en       (ex_mem_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .mem_wb_flush    (mem_wb_flush),
        .mem_timeout_err (mem_timeout_err),
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_flush_cnt  (perf_flush_cnt)
    );

    assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en,
                  if_id_flush, id_ex_flush, mem_wb_flush};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Behavioural model
    // -----------------------------------------------------------------------
    bit m_init  = 1'b1;   // first cycle after reset release
    bit m_err   = 1'b0;   // timed out
    bit m_wait  = 1'b0;   // previous cycle was a dmem freeze
    int m_frz   = 0;      // length of the current freeze run
    int m_stall = 0;
    int m_flush = 0;
    logic [6:0] m_o;

    function automatic logic [6:0] model_out();
        bit ld_use;
        if (!reset_n || m_init || m_err) return C_HOLD;
        // Once frozen, only the acknowledge releases the pipe.
        if (!dmem_ack && (m_wait || mem_access)) return C_FREEZE;
        if (ex_branch_taken) return C_BRANCH;
        ld_use = ex_mem_re && (ex_rd != 5'd0) &&
                 ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        if (ld_use) return C_LDUSE;
        return C_RUN;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_init = 1'b1; m_err = 1'b0; m_wait = 1'b0;
            m_frz = 0; m_stall = 0; m_flush = 0;
        end else begin
            m_o = model_out();
            if (m_init) begin
                m_init = 1'b0;
            end else if (!m_err) begin
                if (!m_o[6] && m_stall < MAXC) m_stall++;
                if (m_o == C_BRANCH && m_flush < MAXC) m_flush++;
                if (m_o == C_FREEZE) begin
                    m_frz++;
                    m_wait = 1'b1;
                    if (m_frz == MT) m_err = 1'b1;
                end else begin
                    m_frz = 0;
                    m_wait = 1'b0;
                end
            end
        end
    end

    // Compare process: outputs are combinational, sampled mid-cycle.
    always @(negedge clk) begin
        check("ctrl", 32'(ctl), 32'(model_out()));
        check("err", 32'(mem_timeout_err), 32'(m_err));
        check("stall_cnt", 32'(perf_stall_cnt), PERF ? 32'(m_stall) : 32'd0);
        check("flush_cnt", 32'(perf_flush_cnt), PERF ? 32'(m_flush) : 32'd0);
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    function automatic vec_t mk(input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2,
                                input logic [4:0] rd, input logic re,
                                input logic br, input logic acc, input logic ack);
        vec_t v;
        v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.rd = rd;
        v.re = re; v.br = br; v.acc = acc; v.ack = ack;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        id_rs1 = v.rs1; id_use_rs1 = v.u1; id_rs2 = v.rs2; id_use_rs2 = v.u2;
        ex_rd = v.rd; ex_mem_re = v.re; ex_branch_taken = v.br;
        mem_access = v.acc; dmem_ack = v.ack;
    endtask

    task automatic step(input vec_t v);
        @(posedge clk);
        #1;
        drive(v);
        @(negedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        drive('0);
        #1;
        check("rst_ctrl", 32'(ctl), 32'(C_HOLD));
        check("rst_err", 32'(mem_timeout_err), 32'd0);
        check("rst_stall_cnt", 32'(perf_stall_cnt), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        check("init_cycle", 32'(ctl), 32'(C_HOLD));
    endtask

    vec_t idle, lu1, lu2, acc_ack, acc_wait, v;

    initial begin
        idle     = '0;
        lu1      = mk(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        lu2      = mk(5'd3, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        acc_ack  = mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        acc_wait = mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(idle);

        rst_pulse();
        step(idle);
        check("run_after_init", 32'(ctl), 32'(C_RUN));

        // Load-use through rs1, then through rs2: one bubble each.
        step(lu1);
        check("lduse_rs1", 32'(ctl), 32'(C_LDUSE));
        step(idle);
        check("lduse_release", 32'(ctl), 32'(C_RUN));
        step(lu2);
        check("lduse_rs2", 32'(ctl), 32'(C_LDUSE));
        // Same registers, but ID does not read rs1 / EX is not a load.
        step(mk(5'd5, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0));
        check("no_use_flag", 32'(ctl), 32'(C_RUN));
        step(mk(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0));
        check("not_load", 32'(ctl), 32'(C_RUN));
        // Load to x0 never stalls.
        step(mk(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        check("x0_load", 32'(ctl), 32'(C_RUN));

        // Branch and load-use together: branch squash wins.
        v = lu1; v.br = 1'b1;
        step(v);
        check("branch_over_lduse", 32'(ctl), 32'(C_BRANCH));
        step(idle);
        check("flush_cnt_one", 32'(perf_flush_cnt), PERF ? 32'd1 : 32'd0);

        // Ack in the same cycle as the access: no stall.
        step(acc_ack);
        check("ack_same_cycle", 32'(ctl), 32'(C_RUN));

        // Three wait cycles, ack on the fourth.
        rst_pulse();
        step(acc_wait);
        check("wait1", 32'(ctl), 32'(C_FREEZE));
        step(acc_wait);
        step(acc_wait);
        check("wait3", 32'(ctl), 32'(C_FREEZE));
        step(acc_ack);
        check("wait_ack", 32'(ctl), 32'(C_RUN));
        step(idle);
        check("stall_cnt_three", 32'(perf_stall_cnt), PERF ? 32'd3 : 32'd0);
        check("no_timeout", 32'(mem_timeout_err), 32'd0);

        // Branch held in EX during a wait is serviced on the ack cycle.
        v = acc_wait; v.br = 1'b1;
        step(v);
        check("branch_frozen", 32'(ctl), 32'(C_FREEZE));
        step(v);
        v.ack = 1'b1;
        step(v);
        check("branch_on_ack", 32'(ctl), 32'(C_BRANCH));

        // Load-use held during a wait becomes a bubble on the ack cycle.
        v = lu1; v.acc = 1'b1;
        step(v);
        check("lduse_frozen", 32'(ctl), 32'(C_FREEZE));
        v.ack = 1'b1;
        step(v);
        check("lduse_on_ack", 32'(ctl), 32'(C_LDUSE));
        step(idle);

        // Timeout: four freeze cycles, then sticky error.
        repeat (4) step(acc_wait);
        check("freeze4", 32'(ctl), 32'(C_FREEZE));
        check("err_not_yet", 32'(mem_timeout_err), 32'd0);
        step(acc_wait);
        check("err_ctrl", 32'(ctl), 32'(C_HOLD));
        check("err_set", 32'(mem_timeout_err), 32'd1);
        step(acc_ack);
        step(idle);
        check("err_sticky", 32'(mem_timeout_err), 32'd1);
        check("err_sticky_ctrl", 32'(ctl), 32'(C_HOLD));
        rst_pulse();
        step(idle);
        check("after_err_reset", 32'(ctl), 32'(C_RUN));

        // Mixed traffic on a small register set, mostly-acknowledged memory.
        for (int i = 0; i < 200; i++) begin
            v = mk(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) != 0));
            step(v);
        end

        // Counter saturation under a held load-use hazard.
        rst_pulse();
        repeat (300) step(lu1);
        step(idle);
        check("stall_cnt_sat", 32'(perf_stall_cnt), PERF ? 32'(MAXC) : 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
